vec_dispatch_unit: RTL and testbench

//  Scalar-side initiator for the vector coprocessor instruction handshake. Buffers {instruction, rs1, rs2}

---
 rtl/vec_dispatch_pkg.sv | 27 ++
 rtl/vec_dispatch_fifo.sv | 52 +++++
 rtl/vec_dispatch_unit.sv | 144 ++++++++++++++
 tb/tb_vec_dispatch_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vec_dispatch_pkg.sv
// rtl/vec_dispatch_pkg.sv - shared types and sizing for the vector dispatch unit
`ifndef XLEN
`define XLEN 32
`endif

package vec_dispatch_pkg;

    localparam int XLEN               = `XLEN;
    localparam int DEF_DEPTH          = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
    localparam int CNT_W              = $clog2(DEF_DEPTH + 1);
    localparam int TMR_W              = $clog2(DEF_TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        RESP
    } dispatch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } disp_entry_t;

endpackage

// File: rtl/vec_dispatch_fifo.sv
// rtl/vec_dispatch_fifo.sv - synchronous FIFO of dispatch entries, no bypass
module vec_dispatch_fifo
    import vec_dispatch_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  disp_entry_t                wdata_i,
    input  logic                       pop_i,
    output disp_entry_t                head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    disp_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/vec_dispatch_unit.sv
// rtl/vec_dispatch_unit.sv - issues queued instructions to the vector coprocessor and returns results
module vec_dispatch_unit
    import vec_dispatch_pkg::*;
#(
    parameter int DEPTH          = DEF_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_valid,
    output logic            push_ready,
    input  logic [XLEN-1:0] push_inst,
    input  logic [XLEN-1:0] push_rs1,
    input  logic [XLEN-1:0] push_rs2,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            inst_valid,
    input  logic            vec_pro_ready,
    input  logic            is_vec,
    output logic            scalar_pro_ready,
    input  logic            vec_pro_ack,
    input  logic [XLEN-1:0] csr_out,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_csr,
    output logic            resp_illegal,
    output logic            resp_timeout,
    output logic            busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    dispatch_state_e               state_q;
    logic [TW-1:0]                 timer_q;
    logic [TW-1:0]                 timer_d;
    disp_entry_t                   payload_q;
    logic                          inst_valid_q;
    logic                          scalar_pro_ready_q;
    logic                          resp_valid_q;
    logic                          resp_illegal_q;
    logic                          resp_timeout_q;
    logic [XLEN-1:0]               resp_csr_q;

    disp_entry_t                   fifo_head;
    logic [$clog2(DEPTH+1)-1:0]    fifo_count;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          fifo_pop;
    disp_entry_t                   push_entry;

    assign push_entry = '{inst: push_inst, rs1: push_rs1, rs2: push_rs2};
    // The head leaves the queue on the same edge the FSM leaves ISSUE
    assign fifo_pop   = (state_q == ISSUE) && (!is_vec || vec_pro_ready);
    assign timer_d    = timer_q + 1'b1;

    vec_dispatch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (push_valid),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= IDLE;
            timer_q            <= '0;
            payload_q          <= '0;
            inst_valid_q       <= 1'b0;
            scalar_pro_ready_q <= 1'b0;
            resp_valid_q       <= 1'b0;
            resp_illegal_q     <= 1'b0;
            resp_timeout_q     <= 1'b0;
            resp_csr_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        payload_q    <= fifo_head;
                        inst_valid_q <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!is_vec) begin
                        inst_valid_q   <= 1'b0;
                        resp_illegal_q <= 1'b1;
                        resp_csr_q     <= '0;
                        resp_valid_q   <= 1'b1;
                        state_q        <= RESP;
                    end else if (vec_pro_ready) begin
                        inst_valid_q       <= 1'b0;
                        scalar_pro_ready_q <= 1'b1;
                        timer_q            <= '0;
                        state_q            <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    timer_q <= timer_d;
                    // ack is tested first so it beats a coincident timeout
                    if (vec_pro_ack) begin
                        resp_csr_q         <= csr_out;
                        scalar_pro_ready_q <= 1'b0;
                        resp_valid_q       <= 1'b1;
                        state_q            <= RESP;
                    end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        resp_timeout_q     <= 1'b1;
                        resp_csr_q         <= '0;
                        scalar_pro_ready_q <= 1'b0;
                        resp_valid_q       <= 1'b1;
                        state_q            <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q   <= 1'b0;
                        resp_illegal_q <= 1'b0;
                        resp_timeout_q <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign push_ready       = !fifo_full;
    assign instruction      = payload_q.inst;
    assign rs1_data         = payload_q.rs1;
    assign rs2_data         = payload_q.rs2;
    assign inst_valid       = inst_valid_q;
    assign scalar_pro_ready = scalar_pro_ready_q;
    assign resp_valid       = resp_valid_q;
    assign resp_illegal     = resp_illegal_q;
    assign resp_timeout     = resp_timeout_q;
    assign resp_csr         = resp_csr_q;
    assign busy             = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_vec_dispatch_unit.sv
// tb/tb_vec_dispatch_unit.sv - directed and randomized checks of vec_dispatch_unit against a queue model
module tb_vec_dispatch_unit;
    import vec_dispatch_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;
    localparam int NO_ACK = 99;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            push_valid = 1'b0;
    logic            push_ready;
    logic [XLEN-1:0] push_inst = '0;
    logic [XLEN-1:0] push_rs1 = '0;
    logic [XLEN-1:0] push_rs2 = '0;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            inst_valid;
    logic            vec_pro_ready = 1'b0;
    logic            is_vec = 1'b1;
    logic            scalar_pro_ready;
    logic            vec_pro_ack = 1'b0;
    logic [XLEN-1:0] csr_out = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [XLEN-1:0] resp_csr;
    logic            resp_illegal;
    logic            resp_timeout;
    logic            busy;

    int n_cmp = 0;
    int n_err = 0;
    disp_entry_t model_q[$];

    vec_dispatch_unit #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_inst(push_inst), .push_rs1(push_rs1), .push_rs2(push_rs2),
        .instruction(instruction), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .inst_valid(inst_valid), .vec_pro_ready(vec_pro_ready), .is_vec(is_vec),
        .scalar_pro_ready(scalar_pro_ready), .vec_pro_ack(vec_pro_ack), .csr_out(csr_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_csr(resp_csr),
        .resp_illegal(resp_illegal), .resp_timeout(resp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [XLEN-1:0] i, input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2);
        disp_entry_t e;
        bit          room;
        room = (model_q.size() < DEPTH);
        chk("push_ready", push_ready, XLEN'(room));
        push_valid = 1'b1;
        push_inst  = i;
        push_rs1   = r1;
        push_rs2   = r2;
        step();
        push_valid = 1'b0;
        if (room) begin
            e.inst = i; e.rs1 = r1; e.rs2 = r2;
            model_q.push_back(e);
        end
    endtask

    // Carries the queue head through issue, completion and response release
    task automatic run_one(input bit vec, input int rdly, input int adly, input int hold,
                           input logic [XLEN-1:0] csr);
        disp_entry_t     exp_e;
        logic [XLEN-1:0] e_csr;
        bit              e_tmo;
        exp_e = '0;
        e_tmo = vec && (adly >= TMO);
        e_csr = (vec && !e_tmo) ? csr : '0;
        for (int k = 0; k < 4 && !inst_valid; k++) step();
        chk("issue_seen", XLEN'(inst_valid), 1);
        if (model_q.size() > 0) exp_e = model_q[0];
        chk("issue_inst", instruction, exp_e.inst);
        chk("issue_rs1", rs1_data, exp_e.rs1);
        chk("issue_rs2", rs2_data, exp_e.rs2);
        chk("issue_spr", XLEN'(scalar_pro_ready), 0);
        if (!vec) begin
            is_vec = 1'b0;
            vec_pro_ready = 1'($urandom_range(0, 1));
            step();
            is_vec = 1'b1;
            vec_pro_ready = 1'b0;
            void'(model_q.pop_front());
            chk("ill_iv", XLEN'(inst_valid), 0);
            chk("ill_spr", XLEN'(scalar_pro_ready), 0);
            chk("ill_valid", XLEN'(resp_valid), 1);
        end else begin
            for (int k = 0; k < rdly; k++) begin
                vec_pro_ack = 1'($urandom_range(0, 1));
                csr_out = $urandom;
                step();
                chk("hold_iv", XLEN'(inst_valid), 1);
                chk("hold_inst", instruction, exp_e.inst);
                chk("hold_rs2", rs2_data, exp_e.rs2);
                chk("hold_resp", XLEN'(resp_valid), 0);
            end
            vec_pro_ack = 1'b0;
            vec_pro_ready = 1'b1;
            step();
            vec_pro_ready = 1'b0;
            void'(model_q.pop_front());
            chk("hs_iv", XLEN'(inst_valid), 0);
            chk("hs_spr", XLEN'(scalar_pro_ready), 1);
            chk("wait_inst", instruction, exp_e.inst);
            chk("ready_after_pop", XLEN'(push_ready), XLEN'(model_q.size() < DEPTH));
            if (e_tmo) begin
                for (int k = 0; k < TMO - 1; k++) begin
                    step();
                    chk("tmo_early", XLEN'(resp_valid), 0);
                end
                step();
            end else begin
                for (int k = 0; k < adly; k++) begin
                    step();
                    chk("ack_early", XLEN'(resp_valid), 0);
                end
                vec_pro_ack = 1'b1;
                csr_out = csr;
                step();
                vec_pro_ack = 1'b0;
                csr_out = $urandom;
            end
            chk("done_valid", XLEN'(resp_valid), 1);
            chk("done_spr", XLEN'(scalar_pro_ready), 0);
        end
        for (int k = 0; k <= hold; k++) begin
            chk("resp_csr", resp_csr, e_csr);
            chk("resp_illegal", XLEN'(resp_illegal), XLEN'(!vec));
            chk("resp_timeout", XLEN'(resp_timeout), XLEN'(e_tmo));
            if (k < hold) begin
                vec_pro_ack = 1'($urandom_range(0, 1));
                csr_out = $urandom;
                step();
                chk("resp_hold", XLEN'(resp_valid), 1);
            end
        end
        vec_pro_ack = 1'b0;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("rel_valid", XLEN'(resp_valid), 0);
        chk("rel_flags", XLEN'({resp_illegal, resp_timeout}), 0);
        chk("bubble_iv", XLEN'(inst_valid), 0);
        chk("idle_busy", XLEN'(busy), XLEN'(model_q.size() != 0));
    endtask

    initial begin
        int n;
        bit v;
        int ad;
        step();
        step();
        chk("rst_push_ready", XLEN'(push_ready), 1);
        chk("rst_iv", XLEN'(inst_valid), 0);
        chk("rst_resp_valid", XLEN'(resp_valid), 0);
        chk("rst_busy", XLEN'(busy), 0);
        chk("rst_inst", instruction, 0);
        chk("rst_csr", resp_csr, 0);
        reset = 1'b0;

        push(32'h0C0572D7, 32'd8, 32'd0);
        run_one(1'b1, 0, 3, 0, 32'd8);

        push(32'h00000013, $urandom, $urandom);
        run_one(1'b0, 0, 0, 1, 32'h0);

        push($urandom, $urandom, $urandom);
        run_one(1'b1, 5, 1, 2, $urandom);

        for (int i = 0; i < 5; i++) push($urandom, $urandom, $urandom);
        chk("full_busy", XLEN'(busy), 1);
        run_one(1'b1, 0, 0, 0, $urandom);
        push($urandom, $urandom, $urandom);
        for (int i = 0; i < 4; i++) run_one(1'b1, 0, 1, 0, $urandom);

        push($urandom, $urandom, $urandom);
        run_one(1'b1, 0, NO_ACK, 1, $urandom);
        push($urandom, $urandom, $urandom);
        run_one(1'b1, 0, TMO - 1, 0, 32'hCAFE_0016);

        for (int i = 0; i < 3; i++) push($urandom, $urandom, $urandom);
        for (int k = 0; k < 4 && !inst_valid; k++) step();
        vec_pro_ready = 1'b1;
        step();
        vec_pro_ready = 1'b0;
        step();
        chk("pre_rst_busy", XLEN'(busy), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_q.delete();
        chk("rst6_iv", XLEN'(inst_valid), 0);
        chk("rst6_busy", XLEN'(busy), 0);
        chk("rst6_push_ready", XLEN'(push_ready), 1);
        chk("rst6_resp", XLEN'(resp_valid), 0);
        chk("rst6_spr", XLEN'(scalar_pro_ready), 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_quiet", XLEN'({inst_valid, resp_valid}), 0);
        end

        for (int it = 0; it < 12; it++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) push($urandom, $urandom, $urandom);
            for (int i = 0; i < n; i++) begin
                v  = ($urandom_range(0, 3) != 0);
                ad = ($urandom_range(0, 5) == 0) ? NO_ACK : $urandom_range(0, TMO - 1);
                run_one(v, $urandom_range(0, 3), ad, $urandom_range(0, 2), $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
